// File: rtl/blocking_reader_array_pkg.sv
// blocking_reader_array_types: section enum, default reset value and saturating add
package blocking_reader_array_types;
    typedef enum logic {READ, WRITE} blocking_reader_array_SECTIONS;
    localparam int DEFAULT_INIT_VAL = 1337;
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] s, hi, lo;
        s = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/blocking_reader_array_if.sv
// blocking_reader_array_if: producer channels, consumer port and threshold bundle
interface blocking_reader_array_if #(parameter int NUM_CH = 4, parameter int DATA_W = 32);
    logic [NUM_CH*DATA_W-1:0] b_in;
    logic [NUM_CH-1:0] b_in_sync, b_in_notify;
    logic [DATA_W-1:0] m_in, b_out;
    logic b_out_sync, b_out_notify, nb_result;
    modport master(output b_in, b_in_sync, m_in, b_out_sync, input b_in_notify, b_out, b_out_notify, nb_result);
    modport slave(input b_in, b_in_sync, m_in, b_out_sync, output b_in_notify, b_out, b_out_notify, nb_result);
endinterface

// File: rtl/blocking_reader_array_chan_select.sv
// chan_select: picks the current channel's word/sync and decodes the next notify one-hot
module chan_select #(parameter int NUM_CH = 4, parameter int DATA_W = 32, parameter int IW = 2) (
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic [NUM_CH-1:0]        sync_vec,
    input  logic [IW-1:0]            sel,
    input  logic [IW-1:0]            dec,
    output logic [DATA_W-1:0]        word,
    output logic                     sync,
    output logic [NUM_CH-1:0]        onehot
);
    assign word = data[sel*DATA_W +: DATA_W];
    assign sync = sync_vec[sel];
    assign onehot = NUM_CH'(1) << dec;
endmodule

// File: rtl/blocking_reader_array.sv
// blocking_reader_array: round-robin blocking reader that sums one word per channel per round
// Define BLOCKING_READER_SAT_EN to saturate the accumulation instead of wrapping.
module blocking_reader_array
    import blocking_reader_array_types::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int INIT_VAL = DEFAULT_INIT_VAL
) (
    input logic clk,
    input logic rst,
    blocking_reader_array_if.slave bus
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    blocking_reader_array_SECTIONS section, section_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic signed [DATA_W-1:0] acc, acc_nxt, result, result_nxt, word, sum;
    logic [NUM_CH-1:0] in_notify, in_notify_nxt, onehot;
    logic out_notify, out_notify_nxt, nb, nb_nxt, sync, rd, wr, last;

    chan_select #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IW(IW)) u_sel (
        .data(bus.b_in), .sync_vec(bus.b_in_sync), .sel(idx), .dec(idx_nxt),
        .word(word), .sync(sync), .onehot(onehot)
    );

    assign rd = section == READ && sync;
    assign wr = section == WRITE && bus.b_out_sync;
    assign last = idx == IW'(NUM_CH - 1);
`ifdef BLOCKING_READER_SAT_EN
    assign sum = DATA_W'(sat_add(64'(acc), 64'(word), DATA_W));
`else
    assign sum = acc + word;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            section    <= READ;
            idx        <= '0;
            acc        <= '0;
            result     <= DATA_W'(INIT_VAL);
            in_notify  <= NUM_CH'(1);
            out_notify <= 1'b0;
            nb         <= 1'b0;
        end else begin
            section    <= section_nxt;
            idx        <= idx_nxt;
            acc        <= acc_nxt;
            result     <= result_nxt;
            in_notify  <= in_notify_nxt;
            out_notify <= out_notify_nxt;
            nb         <= nb_nxt;
        end

    always_comb section_nxt = rd && last ? WRITE : (wr ? READ : section);

    // notify for the next cycle is decoded from idx_nxt, keeping sync->notify registered
    always_comb begin
        idx_nxt        = rd ? (last ? '0 : idx + 1'b1) : idx;
        acc_nxt        = rd ? (last ? '0 : sum) : acc;
        result_nxt     = rd && last ? sum : result;
        nb_nxt         = wr ? (result > $signed(bus.m_in)) : nb;
        out_notify_nxt = rd && last ? 1'b1 : (wr ? 1'b0 : out_notify);
        in_notify_nxt  = rd && last ? '0 : (rd || wr ? onehot : in_notify);
    end

    assign bus.b_in_notify  = in_notify;
    assign bus.b_out        = result;
    assign bus.b_out_notify = out_notify;
    assign bus.nb_result    = nb;
endmodule

// File: doc/blocking_reader_array.md
# blocking_reader_array

Parametrised multi-channel successor of the single blocking-input skeleton block. It reads one word from each of NUM_CH blocking input channels in fixed round-robin order using the sync/notify handshake. It sums the words of one round and delivers the result on a blocking output port. It also reports a threshold comparison against a non-blocking master input. The block sits between NUM_CH producer modules and one consumer, as generated-style glue in the property-checking test designs.

## Interface
- NUM_CH, 4: number of blocking input channels, >= 1
- DATA_W, 32: word width, signed two's complement
- INIT_VAL, 1337: reset value of result register / b_out
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- b_in  in  NUM_CH*DATA_W  channel words, channel i at bits [i*DATA_W +: DATA_W]
- b_in_sync  in  NUM_CH  producer i has valid data
- b_in_notify  out  NUM_CH  block ready to read channel i (one-hot or zero)
- m_in  in  DATA_W  master threshold, sampled without handshake
- b_out  out  DATA_W  round sum (registered)
- b_out_sync  in  1  consumer ready to take b_out
- b_out_notify  out  1  b_out valid
- nb_result  out  1  last delivered sum > m_in (signed)

## Operation
- Sections: READ, WRITE. Registers: section, idx (clog2(NUM_CH), min 1 bit), acc (DATA_W), result (DATA_W, drives b_out), nb_result.
- Reset values: section READ, idx 0, acc 0, result INIT_VAL, b_in_notify only bit 0 = 1, b_out_notify 0, nb_result 0.
- READ: only b_in_notify[idx] is high. A transfer occurs when b_in_notify[idx] & b_in_sync[idx] at a clock edge.
- On a transfer with idx < NUM_CH-1: acc <= acc + word; idx <= idx+1; notify moves to idx+1.
- On a transfer with idx = NUM_CH-1: result <= acc + word; acc <= 0; idx <= 0; b_in_notify <= 0; b_out_notify <= 1; section <= WRITE.
- b_in_sync on non-selected channels is ignored. Their data is not consumed.
- WRITE: all b_in_notify are 0. b_out = result is held stable.
- On b_out_sync & b_out_notify: nb_result <= ($signed(result) > $signed(m_in)); b_out_notify <= 0; b_in_notify[0] <= 1; section <= READ.
- m_in is sampled only at the output handshake edge.
- Arithmetic: DATA_W-bit signed addition, wrap-around by default (see Configuration).
- NUM_CH = 1: each read goes directly to WRITE.
- Reset mid-round: the partial acc is discarded and all registers return to their reset values.

## Timing
- All outputs are registered. There is no combinational path from the sync inputs to the notify outputs.
- Input throughput: one word per cycle while producers hold sync high.
- Latency: the output notify rises on the edge after the last read. Minimum round = NUM_CH read cycles + 1 write cycle.
- After the output handshake edge, b_in_notify[0] is high in the next cycle.
- result and nb_result hold until the next output handshake or reset.

## Configuration
- BLOCKING_READER_SAT_EN defined: every addition saturates to the signed range [-2^(DATA_W-1), 2^(DATA_W-1)-1]. acc clamps, and later additions continue from the clamped value.
- BLOCKING_READER_SAT_EN undefined: modular wrap.
- All other behaviour is identical in both builds.

## Structure
- Package blocking_reader_array_types: enum blocking_reader_array_SECTIONS {READ, WRITE}, localparam default INIT_VAL, and the saturating-add function used under the macro.
- Sub-module chan_select: combinational mux of b_in / b_in_sync by idx, plus one-hot notify decode. The top module holds all state.

## Test plan
1. Reset -> b_in_notify=4'b0001, b_out_notify=0, b_out=1337, nb_result=0.
2. All syncs high, words 1,2,3,4, m_in=5, b_out_sync=1:
   - reads in cycles 1-4; b_out_notify=1 with b_out=10 in cycle 5;
   - after the handshake nb_result=1 and b_in_notify=4'b0001.
3. Same round with b_out_sync low for 3 cycles -> b_out held at 10, b_in_notify=0, no words consumed; handshake on the 4th cycle.
4. Channel 2 sync delayed 5 cycles while channel 3 sync is high -> idx stays 2, channel 3 is not consumed early, and the sum is still correct.
5. Words 0x7FFFFFFF,1,0,0:
   - without the macro, b_out=0x80000000 and nb_result=0 for m_in=0;
   - with BLOCKING_READER_SAT_EN, b_out=0x7FFFFFFF and nb_result=1.
6. rst asserted after 2 reads (words 100,200), then a full round 1,1,1,1 -> b_out=4; all outputs at reset values during rst.
